queen_search_ctrl: RTL

Backtracking controller for the N-queens solver datapath. Sequences two 3-bit up/down loadable counters (row counter, column counter) and the per-row placement memory. It consumes the datapath's conflict flag and drives the counters' en/up_down/ld/Load controls until a placement of N queens is found or the search space is exhausted.

---
 rtl/queen_search_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/queen_search_ctrl.sv
// queen_search_ctrl: backtracking sequencer for the N-queens datapath.
// Optional QUEEN_ENUM_ALL_EN: enumerate every solution, not just the first.
module queen_search_ctrl #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] row_val,
  input  logic [2:0] col_val,
  input  logic       conflict,
  input  logic [2:0] mem_col,
  output logic       row_en,
  output logic       row_up_down,
  output logic       row_ld,
  output logic [2:0] row_load,
  output logic       col_en,
  output logic       col_up_down,
  output logic       col_ld,
  output logic [2:0] col_load,
  output logic       mem_we,
`ifdef QUEEN_ENUM_ALL_EN
  output logic       sol_valid,
  output logic [6:0] sol_count,
`endif
  output logic       busy,
  output logic       done,
  output logic       fail
);

  localparam logic [2:0] LAST = 3'(N - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_PLACE = 3'd2;
  localparam logic [2:0] S_BACK  = 3'd3;
  localparam logic [2:0] S_REST  = 3'd4;
  localparam logic [2:0] S_SOLV  = 3'd5;
  localparam logic [2:0] S_FAIL  = 3'd6;
`ifdef QUEEN_ENUM_ALL_EN
  localparam logic [2:0] S_DALL  = 3'd7;
`endif

  logic [2:0] state;
  logic [2:0] nxt;

  // Decode counter/memory controls and next state from the current state
  always_comb begin
    nxt         = state;
    row_en      = 1'b0;
    row_up_down = 1'b1;
    row_ld      = 1'b0;
    row_load    = 3'd0;
    col_en      = 1'b0;
    col_up_down = 1'b1;
    col_ld      = 1'b0;
    col_load    = 3'd0;
    mem_we      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          row_ld = 1'b1;
          col_ld = 1'b1;
          nxt    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!conflict) begin
          nxt = S_PLACE;
        end else if (col_val < LAST) begin
          col_en = 1'b1;
        end else begin
          nxt = S_BACK;
        end
      end
      S_PLACE: begin
        mem_we = 1'b1;
        if (row_val == LAST) begin
          nxt = S_SOLV;
        end else begin
          row_en = 1'b1;
          col_ld = 1'b1;
          nxt    = S_CHECK;
        end
      end
      S_BACK: begin
        if (row_val == 3'd0) begin
`ifdef QUEEN_ENUM_ALL_EN
          nxt = S_DALL;
`else
          nxt = S_FAIL;
`endif
        end else begin
          row_en      = 1'b1;
          row_up_down = 1'b0;
          nxt         = S_REST;
        end
      end
      S_REST: begin
        if (mem_col == LAST) begin
          nxt = S_BACK;
        end else begin
          col_ld   = 1'b1;
          col_load = mem_col + 3'd1;
          nxt      = S_CHECK;
        end
      end
      S_SOLV: begin
`ifdef QUEEN_ENUM_ALL_EN
        if (col_val < LAST) begin
          col_en = 1'b1;
          nxt    = S_CHECK;
        end else begin
          nxt = S_BACK;
        end
`else
        nxt = S_IDLE;
`endif
      end
      default: nxt = S_IDLE;
    endcase
  end

`ifdef QUEEN_ENUM_ALL_EN
  assign sol_valid = (state == S_SOLV);
`endif

  // State register plus registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      fail  <= 1'b0;
`ifdef QUEEN_ENUM_ALL_EN
      sol_count <= 7'd0;
`endif
    end else begin
      state <= nxt;
      busy  <= (nxt != S_IDLE);
      if (state == S_IDLE && start) begin
        done <= 1'b0;
        fail <= 1'b0;
`ifdef QUEEN_ENUM_ALL_EN
        sol_count <= 7'd0;
`endif
      end
      if (state == S_FAIL) fail <= 1'b1;
`ifdef QUEEN_ENUM_ALL_EN
      if (state == S_SOLV && sol_count != 7'd127)
        sol_count <= sol_count + 7'd1;
      if (state == S_DALL) begin
        done <= (sol_count != 7'd0);
        fail <= (sol_count == 7'd0);
      end
`else
      if (state == S_SOLV) done <= 1'b1;
`endif
    end
  end

endmodule
